// File: rtl/mor1kx_tlb_reload_responder_if.sv
// mor1kx_tlb_reload_responder_if: MMU reload request/ack lines and the Wishbone read master of the reload responder.
// slave is the responder's view; master is the MMU/bus-side view.
interface mor1kx_tlb_reload_responder_if #(
    parameter int WIDTH = 32
);
    logic             dmmu_req_i;
    logic [WIDTH-1:0] dmmu_addr_i;
    logic             dmmu_ack_o;
    logic             immu_req_i;
    logic [WIDTH-1:0] immu_addr_i;
    logic             immu_ack_o;
    logic [WIDTH-1:0] reload_data_o;
    logic             reload_err_o;
    logic [WIDTH-1:0] wbm_adr_o;
    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic             wbm_we_o;
    logic [3:0]       wbm_sel_o;
    logic [2:0]       wbm_cti_o;
    logic [1:0]       wbm_bte_o;
    logic [WIDTH-1:0] wbm_dat_i;
    logic             wbm_ack_i;
    logic             wbm_err_i;

    modport slave (
        input  dmmu_req_i, dmmu_addr_i, immu_req_i, immu_addr_i,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i,
        output dmmu_ack_o, immu_ack_o, reload_data_o, reload_err_o,
        output wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_cti_o, wbm_bte_o
    );

    modport master (
        output dmmu_req_i, dmmu_addr_i, immu_req_i, immu_addr_i,
        output wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  dmmu_ack_o, immu_ack_o, reload_data_o, reload_err_o,
        input  wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_cti_o, wbm_bte_o
    );
endinterface

// File: rtl/mor1kx_tlb_reload_responder.sv
// mor1kx_tlb_reload_responder: round-robin DMMU/IMMU TLB-reload reads, one Wishbone classic read per request.
// Define MOR1KX_TLB_RELOAD_TIMEOUT_EN to fail reads stalled for OPTION_TLB_RELOAD_TIMEOUT cycles.
module mor1kx_tlb_reload_responder #(
    parameter int OPTION_OPERAND_WIDTH      = 32,
    parameter int OPTION_TLB_RELOAD_TIMEOUT = 256
) (
    input logic                          clk,
    input logic                          rst_n,
    mor1kx_tlb_reload_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t                          state;
    logic                            owner;
    logic                            abort;
    logic                            last_grant;
    logic                            grant_i;
    logic                            owner_req;
    logic                            drop;
    logic                            term;
    logic                            fail;
    logic                            expire;
    logic [OPTION_OPERAND_WIDTH-1:0] req_addr;

    if (OPTION_TLB_RELOAD_TIMEOUT < 2 || OPTION_TLB_RELOAD_TIMEOUT > 65535) begin : g_bad_timeout
        $error("OPTION_TLB_RELOAD_TIMEOUT must be in 2..65535");
    end

    // owner/last_grant: 0 = DMMU, 1 = IMMU; on contention the side not served last wins
    assign grant_i   = bus.immu_req_i & (~bus.dmmu_req_i | ~last_grant);
    assign req_addr  = grant_i ? bus.immu_addr_i : bus.dmmu_addr_i;
    assign owner_req = owner ? bus.immu_req_i : bus.dmmu_req_i;
    assign drop      = abort | ~owner_req;
    assign term      = bus.wbm_ack_i | bus.wbm_err_i | expire;
    // any termination without ack (or with err) is a failed read
    assign fail      = bus.wbm_err_i | ~bus.wbm_ack_i;

`ifdef MOR1KX_TLB_RELOAD_TIMEOUT_EN
    logic [15:0] cnt;

    assign expire = cnt == 16'(OPTION_TLB_RELOAD_TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= state == BUS ? cnt + 16'd1 : '0;
    end
`else
    assign expire = 1'b0;
`endif

    assign bus.wbm_we_o  = 1'b0;
    assign bus.wbm_sel_o = 4'hf;
    assign bus.wbm_cti_o = 3'b000;
    assign bus.wbm_bte_o = 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            owner             <= 1'b0;
            abort             <= 1'b0;
            last_grant        <= 1'b1;
            bus.dmmu_ack_o    <= 1'b0;
            bus.immu_ack_o    <= 1'b0;
            bus.reload_data_o <= '0;
            bus.reload_err_o  <= 1'b0;
            bus.wbm_adr_o     <= '0;
            bus.wbm_cyc_o     <= 1'b0;
            bus.wbm_stb_o     <= 1'b0;
        end else begin
            bus.dmmu_ack_o   <= 1'b0;
            bus.immu_ack_o   <= 1'b0;
            bus.reload_err_o <= 1'b0;
            case (state)
                IDLE: if (bus.dmmu_req_i | bus.immu_req_i) begin
                    owner         <= grant_i;
                    bus.wbm_adr_o <= req_addr & ~OPTION_OPERAND_WIDTH'(3);
                    bus.wbm_cyc_o <= 1'b1;
                    bus.wbm_stb_o <= 1'b1;
                    state         <= BUS;
                end
                BUS: begin
                    if (!owner_req)
                        abort <= 1'b1;
                    if (term) begin
                        bus.wbm_cyc_o <= 1'b0;
                        bus.wbm_stb_o <= 1'b0;
                        state         <= RESP;
                        // an abandoned read still completes on the bus but is never reported
                        if (!drop) begin
                            bus.dmmu_ack_o    <= ~owner;
                            bus.immu_ack_o    <= owner;
                            bus.reload_err_o  <= fail;
                            bus.reload_data_o <= fail ? '0 : bus.wbm_dat_i;
                        end
                    end
                end
                default: begin
                    abort      <= 1'b0;
                    last_grant <= owner;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mor1kx_tlb_reload_responder.sv
// tb_mor1kx_tlb_reload_responder: scoreboard bench with a programmable Wishbone slave.
// Define MOR1KX_TLB_RELOAD_TIMEOUT_EN to also exercise the timeout path (timeout 4).
module tb_mor1kx_tlb_reload_responder;
    localparam int W = 32;

    typedef struct packed {
        logic         who;
        logic [W-1:0] data;
        logic         err;
    } resp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mor1kx_tlb_reload_responder_if #(.WIDTH(W)) bus ();

    mor1kx_tlb_reload_responder #(
        .OPTION_OPERAND_WIDTH(W),
        .OPTION_TLB_RELOAD_TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    resp_t        exp_q[$];
    logic [W-1:0] adr_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           s_wait = 0;
    int           s_cnt = 0;
    int           cyc_hi = 0;
    bit           s_err, s_both, s_mute, s_fixed, prev_cyc, ack_seen;
    logic [W-1:0] s_dat;

    function automatic logic [W-1:0] mix(logic [W-1:0] a);
        return a ^ 32'hC3A5_0F1E ^ (a << 7);
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_read(logic who, logic [W-1:0] adr, logic [W-1:0] data, logic err);
        resp_t e;
        e.who  = who;
        e.data = data;
        e.err  = err;
        adr_q.push_back(adr);
        exp_q.push_back(e);
    endtask

    // Wishbone slave: answers after s_wait cycles of cyc&stb, one-cycle ack/err
    task automatic slave();
        if (bus.wbm_ack_i || bus.wbm_err_i) begin
            bus.wbm_ack_i = 1'b0;
            bus.wbm_err_i = 1'b0;
            s_cnt = 0;
        end else if (bus.wbm_cyc_o && bus.wbm_stb_o && !s_mute) begin
            if (s_cnt == s_wait) begin
                bus.wbm_ack_i = !s_err || s_both;
                bus.wbm_err_i = s_err || s_both;
                bus.wbm_dat_i = s_fixed ? s_dat : mix(bus.wbm_adr_o);
            end else
                s_cnt++;
        end else
            s_cnt = 0;
    endtask

    task automatic observe();
        resp_t e;
        ack_seen = 1'b0;
        if (bus.wbm_cyc_o)
            cyc_hi++;
        if (bus.wbm_cyc_o && !prev_cyc) begin
            check("bus_cycle_expected", adr_q.size() > 0, 1);
            if (adr_q.size() > 0)
                check("wbm_adr", bus.wbm_adr_o, adr_q.pop_front());
            check("stb_with_cyc", bus.wbm_stb_o, 1);
        end
        prev_cyc = bus.wbm_cyc_o;
        check("err_needs_ack", bus.reload_err_o && !(bus.dmmu_ack_o || bus.immu_ack_o), 0);
        if (bus.dmmu_ack_o || bus.immu_ack_o) begin
            ack_seen = 1'b1;
            check("single_ack", bus.dmmu_ack_o && bus.immu_ack_o, 0);
            check("cyc_low_in_ack", bus.wbm_cyc_o, 0);
            check("ack_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ack_owner_immu", bus.immu_ack_o, e.who);
                check("reload_data", bus.reload_data_o, e.data);
                check("reload_err", bus.reload_err_o, e.err);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        slave();
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!ack_seen && n < 60);
        check("ack_within_budget", ack_seen, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        bus.dmmu_req_i  = 1'b0;
        bus.dmmu_addr_i = '0;
        bus.immu_req_i  = 1'b0;
        bus.immu_addr_i = '0;
        bus.wbm_dat_i   = '0;
        bus.wbm_ack_i   = 1'b0;
        bus.wbm_err_i   = 1'b0;
        do_reset();

        check("rst_cyc", bus.wbm_cyc_o, 0);
        check("rst_stb", bus.wbm_stb_o, 0);
        check("rst_adr", bus.wbm_adr_o, 0);
        check("rst_dmmu_ack", bus.dmmu_ack_o, 0);
        check("rst_immu_ack", bus.immu_ack_o, 0);
        check("rst_data", bus.reload_data_o, 0);
        check("rst_err", bus.reload_err_o, 0);
        check("we", bus.wbm_we_o, 0);
        check("sel", bus.wbm_sel_o, 4'hf);
        check("cti", bus.wbm_cti_o, 0);
        check("bte", bus.wbm_bte_o, 0);

        // single DMMU read, slave waits 2 cycles: ack 4 cycles after req
        s_fixed = 1'b1;
        s_dat   = 32'hABCD_E000;
        s_wait  = 2;
        expect_read(1'b0, 32'h0000_1004, 32'hABCD_E000, 1'b0);
        bus.dmmu_addr_i = 32'h0000_1004;
        bus.dmmu_req_i  = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!ack_seen && n < 60);
        check("ack_latency", n - 1, 4);
        bus.dmmu_req_i = 1'b0;
        check("ack_one_pulse", bus.dmmu_ack_o, 0);
        check("data_holds", bus.reload_data_o, 32'hABCD_E000);
        s_fixed = 1'b0;
        s_wait  = 0;

        // contention from reset: D, I, then D again before I
        do_reset();
        bus.dmmu_addr_i = 32'h0000_0100;
        bus.immu_addr_i = 32'h0000_0200;
        expect_read(1'b0, 32'h0000_0100, mix(32'h0000_0100), 1'b0);
        expect_read(1'b1, 32'h0000_0200, mix(32'h0000_0200), 1'b0);
        bus.dmmu_req_i = 1'b1;
        bus.immu_req_i = 1'b1;
        wait_ack();
        bus.dmmu_req_i = 1'b0;
        wait_ack();
        expect_read(1'b0, 32'h0000_0104, mix(32'h0000_0104), 1'b0);
        expect_read(1'b1, 32'h0000_0204, mix(32'h0000_0204), 1'b0);
        bus.immu_addr_i = 32'h0000_0204;
        bus.dmmu_addr_i = 32'h0000_0104;
        bus.dmmu_req_i  = 1'b1;
        wait_ack();
        bus.dmmu_req_i = 1'b0;
        wait_ack();
        bus.immu_req_i = 1'b0;

        // follow-on read with new address, low address bits masked
        expect_read(1'b0, 32'h0000_1000, mix(32'h0000_1000), 1'b0);
        expect_read(1'b0, 32'h0020_0008, mix(32'h0020_0008), 1'b0);
        bus.dmmu_addr_i = 32'h0000_1003;
        bus.dmmu_req_i  = 1'b1;
        wait_ack();
        bus.dmmu_addr_i = 32'h0020_0008;
        wait_ack();
        bus.dmmu_req_i = 1'b0;

        // bus error, then ack+err together (err wins)
        s_err = 1'b1;
        expect_read(1'b0, 32'h0000_3000, '0, 1'b1);
        bus.dmmu_addr_i = 32'h0000_3000;
        bus.dmmu_req_i  = 1'b1;
        wait_ack();
        bus.dmmu_req_i = 1'b0;
        s_both = 1'b1;
        expect_read(1'b1, 32'h0000_4000, '0, 1'b1);
        bus.immu_addr_i = 32'h0000_4000;
        bus.immu_req_i  = 1'b1;
        wait_ack();
        bus.immu_req_i = 1'b0;
        check("data_after_err", bus.reload_data_o, 0);
        s_err  = 1'b0;
        s_both = 1'b0;

        // DMMU abandons its read mid-bus; pending IMMU read follows, no DMMU ack
        s_wait = 5;
        adr_q.push_back(32'h0000_5000);
        bus.dmmu_addr_i = 32'h0000_5000;
        bus.dmmu_req_i  = 1'b1;
        step();
        step();
        bus.dmmu_req_i = 1'b0;
        expect_read(1'b1, 32'h0000_5100, mix(32'h0000_5100), 1'b0);
        bus.immu_addr_i = 32'h0000_5100;
        bus.immu_req_i  = 1'b1;
        wait_ack();
        bus.immu_req_i = 1'b0;

        // reset during a bus cycle drops cyc/stb at once with no ack
        adr_q.push_back(32'h0000_6000);
        bus.dmmu_addr_i = 32'h0000_6000;
        bus.dmmu_req_i  = 1'b1;
        step();
        step();
        check("cyc_before_reset", bus.wbm_cyc_o, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_cyc", bus.wbm_cyc_o, 0);
        check("rst_mid_stb", bus.wbm_stb_o, 0);
        bus.dmmu_req_i = 1'b0;
        repeat (3) step();
        rst_n  = 1'b1;
        s_wait = 0;
        expect_read(1'b0, 32'h0000_6100, mix(32'h0000_6100), 1'b0);
        bus.dmmu_addr_i = 32'h0000_6100;
        bus.dmmu_req_i  = 1'b1;
        wait_ack();
        bus.dmmu_req_i = 1'b0;

`ifdef MOR1KX_TLB_RELOAD_TIMEOUT_EN
        // silent slave: read fails after 4 bus cycles
        s_mute = 1'b1;
        cyc_hi = 0;
        expect_read(1'b0, 32'h0000_7000, '0, 1'b1);
        bus.dmmu_addr_i = 32'h0000_7000;
        bus.dmmu_req_i  = 1'b1;
        wait_ack();
        bus.dmmu_req_i = 1'b0;
        check("timeout_bus_cycles", cyc_hi, 4);
        s_mute = 1'b0;
`endif

        repeat (3) step();
        check("exp_q_drained", exp_q.size(), 0);
        check("adr_q_drained", adr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/mor1kx_tlb_reload_responder.md
# mor1kx_tlb_reload_responder

Responder end of the MMU hardware TLB-reload port. It accepts page-table read requests from the DMMU and IMMU (`*_req`/`*_addr`) and arbitrates between them. Each granted request becomes a single Wishbone classic read, and the block returns the fetched word with a one-cycle `*_ack`. It sits between the MMUs and the data-side bus arbiter and is instantiated only when hardware TLB reload is enabled.

## Interface
Parameters:
- OPTION_OPERAND_WIDTH, 32, width of addresses and data.
- OPTION_TLB_RELOAD_TIMEOUT, 256, bus cycles before a stalled read is forced to complete. Range 2..65535. Used only with the timeout macro.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- dmmu_req_i  in  1  DMMU reload request, level, held until ack.
- dmmu_addr_i  in  OPTION_OPERAND_WIDTH  DMMU word address; stable while req is high.
- dmmu_ack_o  out  1  one-cycle completion to DMMU.
- immu_req_i / immu_addr_i / immu_ack_o  same as DMMU, for the IMMU.
- reload_data_o  out  OPTION_OPERAND_WIDTH  read word; valid while either ack is high.
- reload_err_o  out  1  one-cycle pulse with an ack whose read failed (bus error or timeout).
- wbm_adr_o  out  OPTION_OPERAND_WIDTH  bus address, [1:0] forced to 0.
- wbm_cyc_o, wbm_stb_o  out  1  bus cycle/strobe.
- wbm_we_o  out  1  constant 0.
- wbm_sel_o  out  4  constant 4'hf.
- wbm_cti_o  out  3  constant 3'b000.
- wbm_bte_o  out  2  constant 2'b00.
- wbm_dat_i  in  OPTION_OPERAND_WIDTH  bus read data.
- wbm_ack_i, wbm_err_i  in  1  bus termination.

## Operation
- States: IDLE, BUS, RESP. Registers: `owner` (D/I), `abort`, `last_grant`, data register, timeout counter.

**IDLE**
- If any request is high, grant, latch the owner's address into wbm_adr_o, assert cyc/stb and go to BUS.
- Single requester wins.
- When both request, the one not equal to `last_grant` wins (round-robin). `last_grant` resets to I, so the DMMU wins the first contention.

**BUS**
- Hold cyc/stb and the address constant.
- On wbm_ack_i: capture wbm_dat_i and go to RESP.
- On wbm_err_i: capture 0, flag error and go to RESP. A zero word makes the MMU raise a reload pagefault, because the pointer and PRESENT bits are clear.
- If both ack and err are high, err wins.
- If the owner's req drops while in BUS, set `abort`. The bus cycle still runs to termination.

**RESP**
- cyc/stb are low.
- If `abort` is clear, pulse the owner's ack and, if the error is flagged, reload_err_o.
- If `abort` is set, produce no ack and no err pulse. Clear `abort`, update `last_grant` to the owner, and go to IDLE.
- Requests are never sampled in RESP. The requester updates its address on the ack edge and may keep req high for a follow-on read (pointer then PTE); that read is sampled in the following IDLE cycle.
- The non-owner's req is ignored until IDLE; it is never lost.
- reload_data_o holds its last value outside ack cycles.

## Timing
- Reset values: all outputs 0, state IDLE, `abort` 0, `last_grant` I, counter 0.
- Reset asserted mid-transaction drops cyc/stb immediately, with no ack.
- Request high in IDLE at cycle T: cyc/stb high at T+1.
- Bus ack in cycle T+1+k (k ≥ 0): requester ack at T+2+k, with cyc/stb low in the same cycle.
- IDLE at T+3+k; a new request is accepted there, with cyc/stb high at T+4+k.
- Minimum request-to-ack latency is 2 cycles. Throughput is one read per 3 cycles with a zero-wait slave.
- At most one outstanding bus cycle; no pipelining.

## Configuration
- MOR1KX_TLB_RELOAD_TIMEOUT_EN defined:
  - A counter runs in BUS, cleared on entry.
  - If it reaches OPTION_TLB_RELOAD_TIMEOUT-1 with no ack/err, cyc/stb drop, data 0 is captured, the error is flagged and the block goes to RESP.
  - A termination on the same cycle as expiry takes priority over the timeout.
- Undefined: no counter; BUS waits indefinitely for ack/err.

## Test plan
- DMMU req, addr 0x0000_1004, slave acks after 2 cycles with 0xABCD_E000 -> wbm_adr_o 0x0000_1004; dmmu_ack_o one pulse 4 cycles after req, with reload_data_o 0xABCD_E000; no immu_ack_o.
- DMMU and IMMU both request from reset, zero-wait slave -> DMMU served first, then IMMU; a repeated DMMU request after that is served before a repeated IMMU request (alternation).
- DMMU keeps req high after ack and changes addr to 0x0020_0008 on the ack edge -> second bus read uses 0x0020_0008, never the stale address.
- wbm_err_i on a DMMU read -> dmmu_ack_o with reload_data_o 0 and reload_err_o high in the same cycle.
- DMMU drops req during BUS, slave acks later -> bus cycle completes, no dmmu_ack_o, a pending IMMU request is then served.
- With MOR1KX_TLB_RELOAD_TIMEOUT_EN and timeout 4, slave never acks -> cyc/stb drop after 4 BUS cycles; ack with data 0 and reload_err_o.
